// File: rtl/ic_req_responder.sv
// Memory-side responder for I-cache line fetches: queues 48-bit requests, reads 4 words, returns a 128-bit line.
// Optional one-entry line buffer enabled by defining IC_RSP_LINE_BUF_EN.
module ic_req_responder #(
  parameter int         FIFO_DEPTH  = 2,
  parameter int         MEM_AW      = 10,
  parameter logic [1:0] LOCAL_ID    = 2'b00,
  parameter logic [4:0] INSTREQ_CMD = 5'b00110
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_ic_req,
  input  logic [47:0]       req_msg,
  output logic              req_full,
  output logic              mem_re,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              v_inst_4word,
  output logic [127:0]      inst_4word,
  output logic [1:0]        rsp_dst_id,
  output logic              bad_cmd,
  output logic              busy
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;
  state_t state, state_nxt;

  logic [47:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop, dispatch, head_ok, hit;
  logic [47:0]   head, hold;
  logic [1:0]    beat;
  logic [95:0]   work;
  logic          unused_bits;

  assign head     = fifo[rd_ptr];
  assign head_ok  = (head[41:37] == INSTREQ_CMD) && (head[47:46] == LOCAL_ID);
  assign req_full = (count == (PW+1)'(FIFO_DEPTH));
  assign push     = v_ic_req && !req_full;
  // RESP also dispatches the next request so lines stream one per 6 cycles
  assign dispatch = ((state == IDLE) || (state == RESP)) && (count != '0);
  assign pop      = dispatch;

  assign mem_re       = (state == READ);
  assign mem_addr     = {hold[MEM_AW+1:4], beat};
  assign v_inst_4word = (state == RESP);
  assign busy         = (state != IDLE) || (count != '0);
  assign unused_bits  = ^{hold, head};

`ifdef IC_RSP_LINE_BUF_EN
  logic [27:0] tag;
  logic        tag_valid;

  // Record the tag of every delivered line; inst_4word doubles as the buffered data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag       <= 28'd0;
      tag_valid <= 1'b0;
    end else if (state == RESP) begin
      tag       <= hold[31:4];
      tag_valid <= 1'b1;
    end
  end

  // While in RESP the line on inst_4word belongs to hold, not yet to tag
  assign hit = (state == RESP) ? (hold[31:4] == head[31:4])
                               : (tag_valid && (tag == head[31:4]));
`else
  assign hit = 1'b0;
`endif

  // Request queue storage
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= req_msg;
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and drop pulse
  always_comb begin
    state_nxt = state;
    bad_cmd   = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (dispatch) begin
          if (!head_ok) begin
            bad_cmd   = 1'b1;
            state_nxt = IDLE;
          end else if (hit) begin
            state_nxt = RESP;
          end else begin
            state_nxt = READ;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      READ:    state_nxt = (beat == 2'd3) ? DRAIN : READ;
      DRAIN:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Holding register, beat counter and line assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= 48'd0;
      beat       <= 2'd0;
      work       <= 96'd0;
      inst_4word <= 128'd0;
      rsp_dst_id <= 2'd0;
    end else begin
      if (pop) hold <= head;
      if (state == READ) begin
        if (beat != 2'd3) beat <= beat + 2'd1;
        // read data lags mem_re by one cycle, so beat n fills lane n-1
        case (beat)
          2'd1:    work[31:0]  <= mem_rdata;
          2'd2:    work[63:32] <= mem_rdata;
          2'd3:    work[95:64] <= mem_rdata;
          default: work        <= work;
        endcase
      end
      if (state == DRAIN) begin
        beat       <= 2'd0;
        inst_4word <= {mem_rdata, work};
        rsp_dst_id <= hold[44:43];
      end else if (dispatch && head_ok && hit) begin
        rsp_dst_id <= head[44:43];
      end
    end
  end
endmodule

// File: tb/tb_ic_req_responder.sv
// Directed self-checking bench for ic_req_responder; memory word i holds 32'hA000_0000+i.
module tb_ic_req_responder;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         v_ic_req = 1'b0;
  logic [47:0]  req_msg = 48'd0;
  logic         req_full, mem_re, v_inst_4word, bad_cmd, busy;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_rdata = 32'd0;
  logic [127:0] inst_4word;
  logic [1:0]   rsp_dst_id;
  int checks = 0;
  int errors = 0;

  ic_req_responder dut (
    .clk(clk), .rst(rst), .v_ic_req(v_ic_req), .req_msg(req_msg), .req_full(req_full),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .v_inst_4word(v_inst_4word), .inst_4word(inst_4word), .rsp_dst_id(rsp_dst_id),
    .bad_cmd(bad_cmd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Instruction memory with one-cycle read latency
  always @(posedge clk) mem_rdata <= mem_re ? (32'hA000_0000 + {22'd0, mem_addr}) : 32'd0;

  function automatic logic [47:0] mk_req(input logic [1:0] dst, input logic [1:0] src,
                                         input logic [4:0] cmd, input logic [31:0] addr);
    return {dst, 1'b0, src, 1'b0, cmd, 5'b00000, addr};
  endfunction

  function automatic logic [127:0] line_of(input int base);
    logic [31:0] w0;
    w0 = 32'hA000_0000 + base;
    return {w0 + 32'd3, w0 + 32'd2, w0 + 32'd1, w0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({v_inst_4word, inst_4word, rsp_dst_id, mem_re, mem_addr, req_full, bad_cmd, busy} !== 146'd0) begin
      errors++;
      $display("FAIL reset_outputs: got re=%b addr=%0d v=%b full=%b bad=%b busy=%b, want all 0",
               mem_re, mem_addr, v_inst_4word, req_full, bad_cmd, busy);
    end
    rst = 1'b0;
    step();
  endtask

  // Single request from idle: mem_re cycles 2-5, response in cycle 7
  task automatic test_single(input logic [31:0] addr, input logic [1:0] src, input int base,
                             input string name);
    logic exp_re, exp_v;
    v_ic_req = 1'b1;
    req_msg  = mk_req(2'b00, src, 5'b00110, addr);
    for (int c = 0; c < 10; c++) begin
      exp_re = (c >= 2) && (c <= 5);
      exp_v  = (c == 7);
      checks++;
      if (mem_re !== exp_re) begin
        errors++;
        $display("FAIL %s mem_re c%0d: got %b want %b", name, c, mem_re, exp_re);
      end
      if (exp_re) begin
        checks++;
        if (mem_addr !== 10'(base + c - 2)) begin
          errors++;
          $display("FAIL %s mem_addr c%0d: got %0d want %0d", name, c, mem_addr, base + c - 2);
        end
      end
      checks++;
      if (v_inst_4word !== exp_v) begin
        errors++;
        $display("FAIL %s v_inst_4word c%0d: got %b want %b", name, c, v_inst_4word, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (inst_4word !== line_of(base) || rsp_dst_id !== src) begin
          errors++;
          $display("FAIL %s line: got %h id %b want %h id %b", name, inst_4word, rsp_dst_id,
                   line_of(base), src);
        end
      end
      step();
      v_ic_req = 1'b0;
    end
  endtask

  // Bad command and bad destination are both dropped with a bad_cmd pulse in cycle 1
  task automatic test_bad_cmd();
    logic [47:0] vec [2];
    vec[0] = mk_req(2'b00, 2'b01, 5'b00111, 32'h0000_0040);
    vec[1] = mk_req(2'b01, 2'b01, 5'b00110, 32'h0000_0040);
    for (int k = 0; k < 2; k++) begin
      v_ic_req = 1'b1;
      req_msg  = vec[k];
      for (int c = 0; c < 10; c++) begin
        checks++;
        if (bad_cmd !== (c == 1) || mem_re !== 1'b0 || v_inst_4word !== 1'b0) begin
          errors++;
          $display("FAIL bad_cmd vec%0d c%0d: got bad=%b re=%b v=%b want bad=%b re=0 v=0",
                   k, c, bad_cmd, mem_re, v_inst_4word, (c == 1));
        end
        step();
        v_ic_req = 1'b0;
      end
    end
  endtask

  // Three back-to-back requests plus a push while full that coincides with a pop
  task automatic test_back_to_back();
    logic exp_full, exp_re, exp_v;
    logic [1:0] exp_id;
    int exp_base;
    for (int c = 0; c < 28; c++) begin
      v_ic_req = (c <= 2) || (c == 7);
      case (c)
        0:       req_msg = mk_req(2'b00, 2'b10, 5'b00110, 32'h0000_0000);
        1:       req_msg = mk_req(2'b00, 2'b11, 5'b00110, 32'h0000_0100);
        2:       req_msg = mk_req(2'b00, 2'b01, 5'b00110, 32'h0000_03F0);
        default: req_msg = mk_req(2'b00, 2'b00, 5'b00110, 32'h0000_0200);
      endcase
      exp_full = (c >= 3) && (c <= 7);
      exp_re   = ((c >= 2) && (c <= 5)) || ((c >= 8) && (c <= 11)) || ((c >= 14) && (c <= 17));
      exp_v    = (c == 7) || (c == 13) || (c == 19);
      exp_id   = (c == 7) ? 2'b10 : (c == 13) ? 2'b11 : 2'b01;
      exp_base = (c == 7) ? 0 : (c == 13) ? 64 : 252;
      checks++;
      if (req_full !== exp_full) begin
        errors++;
        $display("FAIL b2b req_full c%0d: got %b want %b", c, req_full, exp_full);
      end
      checks++;
      if (mem_re !== exp_re || v_inst_4word !== exp_v) begin
        errors++;
        $display("FAIL b2b timing c%0d: got re=%b v=%b want re=%b v=%b", c, mem_re, v_inst_4word,
                 exp_re, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (inst_4word !== line_of(exp_base) || rsp_dst_id !== exp_id) begin
          errors++;
          $display("FAIL b2b line c%0d: got %h id %b want %h id %b", c, inst_4word, rsp_dst_id,
                   line_of(exp_base), exp_id);
        end
      end
      step();
    end
    v_ic_req = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b busy_end: got %b want 0", busy);
    end
  endtask

  // Reset during READ beat 2 clears outputs at once and cancels the response
  task automatic test_reset_mid();
    v_ic_req = 1'b1;
    req_msg  = mk_req(2'b00, 2'b01, 5'b00110, 32'h0000_0040);
    step();
    v_ic_req = 1'b0;
    step();
    step();
    step();
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 10'd18) begin
      errors++;
      $display("FAIL rst_mid beat2: got re=%b addr=%0d want re=1 addr=18", mem_re, mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({v_inst_4word, inst_4word, rsp_dst_id, mem_re, mem_addr, req_full, bad_cmd, busy} !== 146'd0) begin
      errors++;
      $display("FAIL rst_mid outputs: got re=%b addr=%0d v=%b line=%h busy=%b, want all 0",
               mem_re, mem_addr, v_inst_4word, inst_4word, busy);
    end
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (v_inst_4word !== 1'b0 || mem_re !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid quiet c%0d: got v=%b re=%b busy=%b want 0 0 0", c, v_inst_4word,
                 mem_re, busy);
      end
      step();
    end
    test_single(32'h0000_0040, 2'b01, 16, "rst_mid_fresh");
  endtask

  task automatic test_line_buf();
`ifdef IC_RSP_LINE_BUF_EN
    v_ic_req = 1'b1;
    req_msg  = mk_req(2'b00, 2'b10, 5'b00110, 32'h0000_0040);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (mem_re !== 1'b0 || v_inst_4word !== (c == 2)) begin
        errors++;
        $display("FAIL linebuf hit c%0d: got re=%b v=%b want re=0 v=%b", c, mem_re, v_inst_4word,
                 (c == 2));
      end
      if (c == 2) begin
        checks++;
        if (inst_4word !== line_of(16) || rsp_dst_id !== 2'b10) begin
          errors++;
          $display("FAIL linebuf hit line: got %h id %b want %h id 10", inst_4word, rsp_dst_id,
                   line_of(16));
        end
      end
      step();
      v_ic_req = 1'b0;
    end
    test_single(32'h0000_0050, 2'b11, 20, "linebuf_miss");
`else
    // without the buffer a repeated line is fetched from memory again
    test_single(32'h0000_0040, 2'b10, 16, "repeat_nobuf");
`endif
  endtask

  initial begin
    test_reset();
    test_single(32'h0000_0040, 2'b01, 16, "single");
    test_bad_cmd();
    test_back_to_back();
    test_reset_mid();
    test_line_buf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
